// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/ready handshake, back-pressure and flush.
// Define ID_EX_SKID_EN for the two-entry skid version with a registered id_ready.
module id_ex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int ALUFN_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    ID_PC,
  input  logic [ALUFN_W-1:0] ID_ALUFN,
  input  logic [XLEN-1:0]    ID_A,
  input  logic [XLEN-1:0]    ID_B,
  input  logic [XLEN-1:0]    ID_D,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    EX_PC,
  output logic [ALUFN_W-1:0] EX_ALUFN,
  output logic [XLEN-1:0]    EX_A,
  output logic [XLEN-1:0]    EX_B,
  output logic [XLEN-1:0]    EX_D
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ALUFN_W-1:0] fn;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    d;
  } bundle_t;

  bundle_t id_b, m_q, m_d;
  logic    m_valid_q, m_valid_d;
  logic    accept, drain;

  assign id_b   = {ID_PC, ID_ALUFN, ID_A, ID_B, ID_D};
  assign accept = id_valid & id_ready;
  assign drain  = m_valid_q & ex_ready;

`ifdef ID_EX_SKID_EN
  bundle_t s_q, s_d;
  logic    s_valid_q, s_valid_d;
  logic    rdy_q, rdy_d;

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    if (drain) begin
      if (s_valid_q) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = 1'b0;
      end
    end
    // id_ready is low whenever S holds data, so accept never collides with S->M
    if (accept) begin
      if (!m_valid_q || drain) begin
        m_d       = id_b;
        m_valid_d = 1'b1;
      end else begin
        s_d       = id_b;
        s_valid_d = 1'b1;
      end
    end
    // EX_* must not move on a flush, so M keeps its old data
    if (flush) begin
      m_d       = m_q;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
    rdy_d = !s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      rdy_q     <= rdy_d;
    end
  end

  assign id_ready = rdy_q;
`else
  logic alive_q, alive_d;

  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    alive_d   = 1'b1;
    if (drain)  m_valid_d = 1'b0;
    if (accept) begin
      m_d       = id_b;
      m_valid_d = 1'b1;
    end
    if (flush) begin
      m_d       = m_q;
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      alive_q   <= alive_d;
    end
  end

  // alive_q holds ready low through reset and releases it one edge after
  assign id_ready = alive_q & (!m_valid_q | ex_ready);
`endif

  assign ex_valid = m_valid_q;
  assign {EX_PC, EX_ALUFN, EX_A, EX_B, EX_D} = m_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: FIFO-queue reference model checked every cycle,
// plus directed literal checks; works for both ID_EX_SKID_EN builds.
module tb_id_ex_stage_reg;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [31:0] ID_PC, ID_A, ID_B, ID_D, EX_PC, EX_A, EX_B, EX_D;
  logic [5:0]  ID_ALUFN, EX_ALUFN;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage_reg #(.XLEN(32), .ALUFN_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .ID_PC(ID_PC), .ID_ALUFN(ID_ALUFN), .ID_A(ID_A), .ID_B(ID_B), .ID_D(ID_D),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .EX_PC(EX_PC), .EX_ALUFN(EX_ALUFN), .EX_A(EX_A), .EX_B(EX_B), .EX_D(EX_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of whole bundles with capacity 2 (skid) or 1.
  logic [133:0] q[$];
  logic [133:0] shown = '0;
  bit rdy_r = 0, alive = 0, started = 0, acc_seen = 0;

  function automatic bit model_ready();
`ifdef ID_EX_SKID_EN
    return rdy_r;
`else
    return alive && (q.size() == 0 || ex_ready);
`endif
  endfunction

  always @(posedge clk) begin
    bit acc, drn;
    acc      = id_valid && model_ready();
    drn      = (q.size() > 0) && ex_ready;
    started  = 1;
    acc_seen = 0;
    if (rst) begin
      q.delete();
      shown = '0;
      alive = 0;
      rdy_r = 0;
    end else if (flush) begin
      q.delete();
      acc_seen = acc;
      alive    = 1;
      rdy_r    = 1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back({ID_PC, ID_ALUFN, ID_A, ID_B, ID_D});
        acc_seen = 1;
      end
      if (q.size() > 0) shown = q[0];
      alive = 1;
      rdy_r = q.size() < 2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("id_ready", {133'd0, id_ready}, {133'd0, model_ready()});
      chk("ex_valid", {133'd0, ex_valid}, {133'd0, q.size() > 0});
      chk("ex_bundle", {EX_PC, EX_ALUFN, EX_A, EX_B, EX_D}, shown);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    id_valid = v;
    ID_PC    = pc;
    ID_ALUFN = pc[7:2] ^ 6'h2a;
    ID_A     = pc ^ 32'hA5A5_0000;
    ID_B     = ~pc;
    ID_D     = pc + 32'd7;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, {102'd0, act}, {102'd0, exp});
  endtask

  initial begin
    logic [31:0] pc;
    // reset with all-ones inputs offered
    rst = 1; flush = 0; ex_ready = 0;
    id_valid = 1; ID_PC = '1; ID_ALUFN = '1; ID_A = '1; ID_B = '1; ID_D = '1;
    #1;
    step(); step();
    lit("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    lit("rst_ex_pc", EX_PC, 32'h0);
    lit("rst_ex_a", EX_A, 32'h0);
    lit("rst_ex_alufn", {26'd0, EX_ALUFN}, 32'h0);
    lit("rst_id_ready", {31'd0, id_ready}, 32'd0);
    rst = 0; offer(0, 32'h0);
    #1;
    lit("rst_drop_ready_low", {31'd0, id_ready}, 32'd0);
    step();
    lit("rst_after_ready", {31'd0, id_ready}, 32'd1);

    // streaming
    ex_ready = 1;
    offer(1, 32'h100); step();
    lit("stream_0", EX_PC, 32'h100);
    offer(1, 32'h104); step();
    lit("stream_1", EX_PC, 32'h104);
    lit("stream_1_valid", {31'd0, ex_valid}, 32'd1);
    offer(1, 32'h108); step();
    lit("stream_2", EX_PC, 32'h108);
    lit("stream_2_b", EX_B, ~32'h108);
    offer(0, 32'h0); step();
    lit("stream_empty", {31'd0, ex_valid}, 32'd0);
    lit("stream_hold", EX_PC, 32'h108);

`ifdef ID_EX_SKID_EN
    ex_ready = 0;
    offer(1, 32'h200); step();
    lit("bp_m", EX_PC, 32'h200);
    offer(1, 32'h204); step();
    lit("bp_full_ready", {31'd0, id_ready}, 32'd0);
    offer(1, 32'h208); step();
    lit("bp_held_ready", {31'd0, id_ready}, 32'd0);
    lit("bp_held_pc", EX_PC, 32'h200);
    ex_ready = 1; step();
    lit("bp_out_1", EX_PC, 32'h204);
    lit("bp_ready_back", {31'd0, id_ready}, 32'd1);
    step();
    lit("bp_out_2", EX_PC, 32'h208);
    offer(0, 32'h0); step();
`else
    ex_ready = 0;
    offer(1, 32'h200); step();
    lit("ns_m", EX_PC, 32'h200);
    lit("ns_ready_low", {31'd0, id_ready}, 32'd0);
    ex_ready = 1; offer(1, 32'h204);
    #1;
    lit("ns_ready_comb", {31'd0, id_ready}, 32'd1);
    step();
    lit("ns_next", EX_PC, 32'h204);
    offer(0, 32'h0); step();
`endif

    // flush with entries held and a bundle offered
    ex_ready = 0;
    offer(1, 32'h300); step();
    offer(1, 32'h304); step();
    offer(1, 32'h308); flush = 1; step();
    lit("fl_valid", {31'd0, ex_valid}, 32'd0);
    lit("fl_pc", EX_PC, 32'h300);
    lit("fl_ready", {31'd0, id_ready}, 32'd1);
    offer(1, 32'h30C); step();
    lit("fl_accept_drop", {31'd0, ex_valid}, 32'd0);
    lit("fl_accept_pc", EX_PC, 32'h300);
    flush = 0; offer(0, 32'h0); step();

    // reset beats flush and accept
    rst = 1; flush = 1; ex_ready = 1; offer(1, 32'h400); step();
    lit("pri_valid", {31'd0, ex_valid}, 32'd0);
    lit("pri_pc", EX_PC, 32'h0);
    rst = 0; flush = 0; offer(0, 32'h0); step(); step();
    lit("pri_after_pc", EX_PC, 32'h0);

    // mixed valid/ready/flush pattern, checked by the model every cycle
    pc = 32'h500;
    for (int i = 0; i < 60; i++) begin
      ex_ready = (i % 4 != 1) && (i % 7 != 3);
      flush    = (i == 33);
      offer(i % 5 != 2, pc);
      step();
      if (acc_seen) pc = pc + 32'd4;
    end
    flush = 0; ex_ready = 1; offer(0, 32'h0);
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
